// File: rtl/spi_sched_pkg.sv
// Shared constants for the SPI transfer scheduler: byte width, defaults,
// FSM state encodings and a small index helper.
package spi_sched_pkg;

    localparam int SPI_BYTE_W  = 8;
    localparam int DEF_N_REQ   = 4;
    localparam int DEF_GAP_CYC = 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_CAPT  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    function automatic int wrap_inc(input int i, input int n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr.
module spi_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!gnt_vld && req[(int'(ptr) + k) % N_REQ]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/spi_xfer_sched.sv
// Round-robin byte-transfer scheduler in front of an SPI master shift engine.
// Optional chip-select locking is enabled with `define SPI_SCHED_LOCK_EN.
module spi_xfer_sched
    import spi_sched_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int SHIFT_LEN = SPI_BYTE_W,
    parameter int GAP_CYC   = DEF_GAP_CYC
) (
    input  logic                        mclk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
`ifdef SPI_SCHED_LOCK_EN
    input  logic [N_REQ-1:0]            lock,
`endif
    input  logic [SPI_BYTE_W*N_REQ-1:0] tx_data,
    output logic [N_REQ-1:0]            done,
    output logic [SPI_BYTE_W-1:0]       rx_data,
    output logic                        busy,
    output logic [N_REQ-1:0]            cs_n,
    output logic                        spi_load,
    output logic                        spi_start,
    output logic                        spi_read,
    output logic [SPI_BYTE_W-1:0]       spi_data_in,
    input  logic [SPI_BYTE_W-1:0]       spi_data_out
);

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_MAX = (SHIFT_LEN > GAP_CYC) ? SHIFT_LEN : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [2:0]            state;
    logic [IDX_W-1:0]      gnt;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_vld;
    logic [CNT_W-1:0]      cnt;
    logic                  locked;
    logic                  in_xfer;
    logic [SPI_BYTE_W-1:0] tx_sel;

    spi_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    assign tx_sel  = tx_data[SPI_BYTE_W*gnt +: SPI_BYTE_W];
    assign in_xfer = (state == S_LOAD) || (state == S_SHIFT) ||
                     (state == S_LATCH) || (state == S_CAPT);

    // Engine controls and selects decode straight from registered state.
    always_comb begin
        spi_start   = in_xfer;
        spi_load    = (state == S_LOAD);
        spi_read    = (state == S_LATCH) || (state == S_CAPT);
        spi_data_in = (state == S_LOAD) ? tx_sel : '0;
        busy        = (state != S_IDLE) || locked;
        cs_n        = '1;
        if (in_xfer || locked)
            cs_n[gnt] = 1'b0;
    end

`ifndef SPI_SCHED_LOCK_EN
    assign locked = 1'b0;
`endif

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            gnt     <= '0;
            rr_ptr  <= '0;
            cnt     <= '0;
            done    <= '0;
            rx_data <= '0;
`ifdef SPI_SCHED_LOCK_EN
            locked  <= 1'b0;
`endif
        end else begin
            done <= '0;
            case (state)
                S_IDLE: begin
`ifdef SPI_SCHED_LOCK_EN
                    // Held select: continue with the same requester or release.
                    if (locked) begin
                        locked <= 1'b0;
                        if (req[gnt]) begin
                            state <= S_LOAD;
                        end else begin
                            rr_ptr <= IDX_W'(wrap_inc(int'(gnt), N_REQ));
                            state  <= (GAP_CYC == 0) ? S_IDLE : S_GAP;
                        end
                    end else
`endif
                    if (arb_vld) begin
                        gnt   <= arb_idx;
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt   <= '0;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(SHIFT_LEN - 1))
                        state <= S_LATCH;
                end
                S_LATCH: state <= S_CAPT;
                S_CAPT: begin
                    rx_data   <= spi_data_out;
                    done[gnt] <= 1'b1;
                    cnt       <= '0;
`ifdef SPI_SCHED_LOCK_EN
                    if (lock[gnt]) begin
                        locked <= 1'b1;
                        state  <= S_IDLE;
                    end else
`endif
                    begin
                        rr_ptr <= IDX_W'(wrap_inc(int'(gnt), N_REQ));
                        state  <= (GAP_CYC == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(GAP_CYC - 1))
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_sched.sv
// Directed bench for spi_xfer_sched with a behavioural SPI shift engine.
module tb_spi_xfer_sched;

    logic        mclk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] tx_data;
    logic [3:0]  done;
    logic [7:0]  rx_data;
    logic        busy;
    logic [3:0]  cs_n;
    logic        spi_load, spi_start, spi_read;
    logic [7:0]  spi_data_in, spi_data_out;

    int errors = 0;
    int checks = 0;

    spi_xfer_sched #(.N_REQ(4), .SHIFT_LEN(8), .GAP_CYC(1)) dut (
        .mclk         (mclk),
        .reset        (reset),
        .req          (req),
`ifdef SPI_SCHED_LOCK_EN
        .lock         (lock),
`endif
        .tx_data      (tx_data),
        .done         (done),
        .rx_data      (rx_data),
        .busy         (busy),
        .cs_n         (cs_n),
        .spi_load     (spi_load),
        .spi_start    (spi_start),
        .spi_read     (spi_read),
        .spi_data_in  (spi_data_in),
        .spi_data_out (spi_data_out)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Engine model: MSB-first shift, miso either loopback or a fixed pattern.
    logic [7:0] eng_sr, eng_out, pat_sr, miso_pat;
    logic       rd_d, loopback, miso;

    assign miso         = loopback ? eng_sr[7] : pat_sr[7];
    assign spi_data_out = spi_read ? eng_out : 8'h00;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            eng_sr  <= '0;
            eng_out <= '0;
            pat_sr  <= '0;
            rd_d    <= 1'b0;
        end else begin
            rd_d <= spi_read;
            if (spi_load) begin
                eng_sr <= spi_data_in;
                pat_sr <= miso_pat;
            end else if (spi_start && !spi_read) begin
                eng_sr <= {eng_sr[6:0], miso};
                pat_sr <= {pat_sr[6:0], 1'b0};
            end
            if (spi_read && !rd_d)
                eng_out <= eng_sr;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge mclk);
        #1;
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        case (v)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 15;
        endcase
    endfunction

    // Follows one transfer from its grant cycle; clears req once done shows.
    task automatic watch(input int lane, input int drop_at, input int max_cyc,
                         output int done_cyc, output logic [3:0] done_val,
                         output logic [7:0] rx, output int low_cnt,
                         output int din_cnt, output logic [7:0] din_load);
        logic [3:0] cs_exp;
        cs_exp   = ~(4'b0001 << lane);
        done_cyc = 0;
        done_val = '0;
        rx       = '0;
        low_cnt  = 0;
        din_cnt  = 0;
        din_load = '0;
        for (int c = 1; c <= max_cyc; c++) begin
            step();
            if (c == drop_at) req = 4'b0000;
            if (cs_n == cs_exp) low_cnt++;
            if (spi_data_in != 8'h00) din_cnt++;
            if (c == 1) din_load = spi_load ? spi_data_in : 8'hxx;
            if (done != 4'b0000 && done_cyc == 0) begin
                done_cyc = c;
                done_val = done;
                rx       = rx_data;
                req      = 4'b0000;
            end
        end
    endtask

    int         dc, lc, dn;
    logic [3:0] dv;
    logic [7:0] rxv, dl;
    int         d_idx[5];
    int         d_cyc[5];
    int         nd;

    initial begin
        reset    = 1'b0;
        req      = '0;
        lock     = '0;
        tx_data  = '0;
        loopback = 1'b1;
        miso_pat = '0;
        step(); step();
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_ctl", {busy, spi_load, spi_start, spi_read}, 4'b0000);
        check("rst_done_rx", {done, rx_data}, 12'h000);
        reset = 1'b1;
        step();

        // Single request on lane 1, loopback.
        tx_data[15:8] = 8'hA5;
        req = 4'b0010;
        watch(1, 0, 16, dc, dv, rxv, lc, dn, dl);
        check("t1_done_cyc", dc, 12);
        check("t1_done_val", dv, 4'b0010);
        check("t1_rx", rxv, 8'hA5);
        check("t1_cs_low_cycles", lc, 11);
        check("t1_load_data", dl, 8'hA5);
        check("t1_din_cycles", dn, 1);

        // All four requesting from a freshly reset pointer.
        reset = 1'b0;
        step();
        reset = 1'b1;
        tx_data = 32'h44332211;
        req = 4'b1111;
        nd = 0;
        for (int c = 1; c <= 70; c++) begin
            step();
            if (done != 4'b0000 && nd < 5) begin
                d_idx[nd] = oh_idx(done);
                d_cyc[nd] = c;
                nd++;
                if (nd == 5) req = 4'b0000;
            end
        end
        check("t2_count", nd, 5);
        check("t2_first_cyc", d_cyc[0], 12);
        for (int k = 0; k < 5; k++)
            check($sformatf("t2_order%0d", k), d_idx[k], k % 4);
        for (int k = 1; k < 5; k++)
            check($sformatf("t2_spacing%0d", k), d_cyc[k] - d_cyc[k-1], 13);

        // req[2] dropped mid-shift: transfer still completes.
        tx_data[23:16] = 8'h5A;
        req = 4'b0100;
        watch(2, 4, 16, dc, dv, rxv, lc, dn, dl);
        check("t3_done_cyc", dc, 12);
        check("t3_done_val", dv, 4'b0100);
        check("t3_rx", rxv, 8'h5A);
        step(); step(); step();
        check("t3_idle", {busy, cs_n}, 5'b0_1111);

        // Reset in the fourth shift cycle.
        tx_data[31:24] = 8'h77;
        req = 4'b1000;
        for (int c = 1; c <= 5; c++) step();
        reset = 1'b0;
        #1;
        check("t4_cs_n", cs_n, 4'hF);
        check("t4_start_busy", {spi_start, busy}, 2'b00);
        req = 4'b0000;
        step();
        reset = 1'b1;
        nd = 0;
        for (int c = 1; c <= 15; c++) begin
            step();
            if (done != 4'b0000) nd++;
        end
        check("t4_no_done", nd, 0);
        req = 4'b1000;
        watch(3, 0, 16, dc, dv, rxv, lc, dn, dl);
        check("t4_after_done_cyc", dc, 12);
        check("t4_after_rx", rxv, 8'h77);
        check("t4_after_done_val", dv, 4'b1000);

        // Patterned miso, tx all ones.
        loopback = 1'b0;
        miso_pat = 8'h3C;
        tx_data[7:0] = 8'hFF;
        req = 4'b0001;
        watch(0, 0, 16, dc, dv, rxv, lc, dn, dl);
        check("t5_rx", rxv, 8'h3C);
        check("t5_din_cycles", dn, 1);
        check("t5_load_data", dl, 8'hFF);
        check("t5_cs_low_cycles", lc, 11);
        loopback = 1'b1;

`ifdef SPI_SCHED_LOCK_EN
        // Lock lane 0 over two transfers while lane 1 waits.
        reset = 1'b0;
        step();
        reset = 1'b1;
        tx_data[7:0]  = 8'h11;
        tx_data[15:8] = 8'h22;
        lock = 4'b0001;
        req  = 4'b0011;
        nd = 0;
        lc = 0;
        dn = 0;
        d_cyc[0] = 0; d_cyc[1] = 0; d_cyc[2] = 0;
        rxv = '0;
        for (int c = 1; c <= 50; c++) begin
            step();
            if (c <= 23 && cs_n[0] == 1'b0) lc++;
            if (c <= 23 && cs_n == 4'hF) dn++;
            if (done == 4'b0001 && nd < 2) begin
                d_cyc[nd] = c;
                nd++;
                if (nd == 1) lock = 4'b0000;
                else req[0] = 1'b0;
            end
            if (done == 4'b0010 && d_cyc[2] == 0) begin
                d_cyc[2] = c;
                rxv = rx_data;
                req[1] = 1'b0;
            end
        end
        check("lk_done0_first", d_cyc[0], 12);
        check("lk_done0_second", d_cyc[1], 24);
        check("lk_done1", d_cyc[2], 37);
        check("lk_cs0_low", lc, 23);
        check("lk_no_gap", dn, 0);
        check("lk_rx1", rxv, 8'h22);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
